// File: rtl/hash_arbiter_if.sv
// Request/result/config bundle for hash_arbiter.
// master drives keys, mask writes and out_ready; slave is the arbiter.
interface hash_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][IN_WIDTH-1:0]  req_key;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              cfg_we;
  logic [OUT_WIDTH-1:0]              cfg_mask;
  logic                              out_valid;
  logic [OUT_WIDTH-1:0]              out_hash;
  logic [ID_W-1:0]                   out_id;
  logic                              out_ready;
  logic [NUM_REQ-1:0][15:0]          cnt;

  modport master (
    output req_valid, req_key, cfg_we, cfg_mask, out_ready,
    input  req_ready, out_valid, out_hash, out_id, cnt
  );

  modport slave (
    input  req_valid, req_key, cfg_we, cfg_mask, out_ready,
    output req_ready, out_valid, out_hash, out_id, cnt
  );
endinterface

// File: rtl/hash_arbiter.sv
// Round-robin key arbiter feeding a one-stage masked hash.
// One grant per cycle into a single output slot with backpressure.
module tree_hash #(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  key,
  input  logic [OUT_WIDTH-1:0] mask,
  output logic [OUT_WIDTH-1:0] hash
);
  // Middle key bits do not take part in the fold.
  logic unused_mid;
  assign unused_mid = ^key[IN_WIDTH-OUT_WIDTH-1:OUT_WIDTH];

  // Fold the top byte onto the bottom byte, then apply the mask.
  assign hash = (key[OUT_WIDTH-1:0]
              ^ key[IN_WIDTH-1 -: OUT_WIDTH]) & mask;
endmodule

module hash_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  hash_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [OUT_WIDTH-1:0]      mask_q, mask_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]      out_hash_q, out_hash_d;
  logic [ID_W-1:0]           out_id_q, out_id_d;
  logic [NUM_REQ-1:0][15:0]  cnt_q, cnt_d;

  logic                      free;
  logic                      gnt_any;
  logic [NUM_REQ-1:0]        gnt_vec;
  logic [ID_W-1:0]           gnt_id;
  logic [IN_WIDTH-1:0]       gnt_key;
  logic [OUT_WIDTH-1:0]      gnt_hash;

  assign free = !out_valid_q || bus.out_ready;

  // Pick the first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vec = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any      = 1'b1;
        gnt_vec[idx] = 1'b1;
        gnt_id       = ID_W'(idx);
      end
    end
    if (!free || rst) begin
      gnt_vec = '0;
      gnt_any = 1'b0;
    end
  end

  assign gnt_key = bus.req_key[gnt_id];

  tree_hash #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_hash (
    .key  (gnt_key),
    .mask (mask_q),
    .hash (gnt_hash)
  );

  // Next state for output slot, pointer, mask and counters.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_hash_d  = out_hash_q;
    out_id_d    = out_id_q;
    cnt_d       = cnt_q;
    if (bus.cfg_we) mask_d = bus.cfg_mask;
    if (gnt_any) begin
      out_valid_d = 1'b1;
      out_hash_d  = gnt_hash;
      out_id_d    = gnt_id;
      if (int'(gnt_id) == NUM_REQ - 1) rr_ptr_d = '0;
      else rr_ptr_d = gnt_id + ID_W'(1);
      if (cnt_q[gnt_id] != 16'hFFFF)
        cnt_d[gnt_id] = cnt_q[gnt_id] + 16'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      mask_q      <= '1;
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      out_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_hash_q  <= out_hash_d;
      out_id_q    <= out_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = gnt_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_hash  = out_hash_q;
  assign bus.out_id    = out_id_q;
  assign bus.cnt       = cnt_q;
endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter IN_WIDTH, default 40, key width (fixed at 40).
REQ-003 SHALL have parameter OUT_WIDTH, default 8, hash width (fixed at 8).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester key valid.
REQ-007 SHALL have port req_key  input  NUM_REQ x IN_WIDTH  per-requester key.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot-or-zero grant/accept.
REQ-009 SHALL have port cfg_we  input  1  mask write strobe.
REQ-010 SHALL have port cfg_mask  input  OUT_WIDTH  new mask value.
REQ-011 SHALL have port out_valid  output  1  hashed result valid.
REQ-012 SHALL have port out_hash  output  OUT_WIDTH  masked hash.
REQ-013 SHALL have port out_id  output  clog2(NUM_REQ) (min 1)  index of the requester that produced out_hash.
REQ-014 SHALL have port out_ready  input  1  downstream accept.
REQ-015 SHALL have port cnt  output  NUM_REQ x 16  per-requester accepted-key counters.

Function
REQ-016 SHALL compute the hash with one internal tree_hash instance (IN_WIDTH=40, OUT_WIDTH=8); result SHALL equal (key[7:0] ^ key[39:32]) & mask.
REQ-017 SHALL hold a mask register driving the tree_hash mask input.
REQ-018 Mask register SHALL load cfg_mask on the edge where cfg_we=1; a grant in that same cycle SHALL use the old mask.
REQ-019 Slot free condition: free = !out_valid || out_ready.
REQ-020 When free and at least one req_valid is high, SHALL assert exactly one req_ready bit, chosen round-robin from pointer rr_ptr upward with wrap (index NUM_REQ-1 wraps to 0).
REQ-021 When not free, or no req_valid is high, all req_ready bits SHALL be 0.
REQ-022 req_ready SHALL be combinational from req_valid, rr_ptr, out_valid and out_ready; no dependence on req_key.
REQ-023 On a grant to requester g: at the next edge out_valid=1, out_hash=hash(req_key[g]), out_id=g, rr_ptr=(g+1) mod NUM_REQ.
REQ-024 Latency: key accepted in cycle N appears on out_* in cycle N+1.
REQ-025 Full throughput: one grant per cycle when out_ready is held high.
REQ-026 When out_valid=1 and out_ready=0, out_valid, out_hash and out_id SHALL hold stable.
REQ-027 When out_valid=1, out_ready=1 and no grant occurs, out_valid SHALL clear at the next edge.
REQ-028 rr_ptr SHALL change only on a grant.
REQ-029 cnt[g] SHALL increment by 1 on each grant to g and saturate at 0xFFFF.
REQ-030 A requester dropping req_valid without a grant SHALL lose nothing and change no state.

Reset
REQ-031 On rst=1 at an edge: out_valid=0, out_hash=0, out_id=0, rr_ptr=0, mask=0xFF, all cnt=0.
REQ-032 While rst=1, req_ready SHALL be all zero.
REQ-033 rst SHALL override a simultaneous grant or cfg_we; an in-flight result SHALL be discarded, not delivered.

Verification
REQ-034 Single key: mask=0xFF, req 0 key=0x3C000000A5, out_ready=1 -> next cycle out_valid=1, out_hash=0x99, out_id=0, cnt[0]=1.
REQ-035 Mask: cfg_we with cfg_mask=0x0F, then key=0x00000000A5 -> out_hash=0x05; cfg_we in the same cycle as the grant -> out_hash=0xA5.
REQ-036 Fairness: both requesters valid every cycle, out_ready=1 -> out_id sequence 0,1,0,1,... and cnt equal after 10 cycles (5/5).
REQ-037 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0 and out_* stable; out_ready=1 -> same-cycle grant, next result follows back-to-back.
REQ-038 Reset mid-flight: rst during out_valid=1 and an active grant -> next cycle out_valid=0, cnt=0, mask=0xFF, rr_ptr=0.
REQ-039 Saturation: preload via 65,536 grants to requester 1 -> cnt[1]=0xFFFF and stays there on further grants.
